// File: rtl/arith_issue.sv
// Issue/collect controller for the mult_compute pipeline: issues operand pairs, tracks them
// through a fixed-latency tracker, and captures results into a credit-protected FWFT FIFO.
// Optional macro ARITH_ISSUE_DROP_DIRTY_EN discards dirty results and counts them in drop_cnt.
module arith_issue #(
    parameter int LAT   = 4,
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [23:0]               in_a,
    input  logic [23:0]               in_b,
    input  logic                      in_dirty,
    input  logic [TAG_W-1:0]          in_tag,
    output logic [24:0]               element1,
    output logic [23:0]               element2,
    input  logic [24:0]               new1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [23:0]               out_data,
    output logic                      out_dirty,
    output logic [TAG_W-1:0]          out_tag,
    output logic [$clog2(LAT+2)-1:0]  inflight,
    output logic [15:0]               drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IF_W  = $clog2(LAT+2);

    typedef struct packed {
        logic             dirty;
        logic [23:0]      data;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic                  issue, capture, push, pop;
    logic [LAT:0]          vld_pipe;
    logic [LAT:0][TAG_W-1:0] tag_pipe;
    res_t                  fifo_mem [DEPTH];
    res_t                  cap_res, head;
    logic [PTR_W-1:0]      wptr, rptr;
    logic [CNT_W-1:0]      fifo_count;

    // Credit check uses registered state only, so a same-cycle pop never frees a slot early.
    assign in_ready  = !reset && ((int'(fifo_count) + int'(inflight)) < DEPTH);
    assign issue     = in_valid && in_ready;
    assign capture   = vld_pipe[LAT];
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign cap_res   = '{dirty: new1[24], data: new1[23:0], tag: tag_pipe[LAT]};

`ifdef ARITH_ISSUE_DROP_DIRTY_EN
    assign push = capture && !new1[24];
`else
    assign push = capture;
`endif

    always_ff @(posedge clock) begin
        if (reset || !issue) begin
            element1 <= '0;
            element2 <= '0;
        end else begin
            element1 <= {in_dirty, in_a};
            element2 <= in_b;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[LAT-1:0], issue};
    end

    always_ff @(posedge clock) begin
        tag_pipe <= {tag_pipe[LAT-1:0], in_tag};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({issue, capture})
                2'b10:   inflight <= inflight + IF_W'(1);
                2'b01:   inflight <= inflight - IF_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wptr] <= cap_res;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign head      = fifo_mem[rptr];
    assign out_data  = head.data;
    assign out_dirty = head.dirty;
    assign out_tag   = head.tag;

`ifdef ARITH_ISSUE_DROP_DIRTY_EN
    always_ff @(posedge clock) begin
        if (reset)
            drop_cnt <= '0;
        else if (capture && new1[24] && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_arith_issue.sv
// Scoreboard bench for arith_issue with an add-based stand-in for the mult_compute pipeline.
module tb_arith_issue;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int TAG_W = 4;

    logic              clock, reset;
    logic              in_valid, in_ready, in_dirty;
    logic [23:0]       in_a, in_b;
    logic [TAG_W-1:0]  in_tag;
    logic [24:0]       element1, new1;
    logic [23:0]       element2;
    logic              out_valid, out_ready, out_dirty;
    logic [23:0]       out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [$clog2(LAT+2)-1:0] inflight;
    logic [15:0]       drop_cnt;

    typedef struct packed {
        logic             d;
        logic [23:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    arith_issue #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_dirty(in_dirty), .in_tag(in_tag),
        .element1(element1), .element2(element2), .new1(new1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dirty(out_dirty), .out_tag(out_tag),
        .inflight(inflight), .drop_cnt(drop_cnt)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    // Pipeline stand-in: LAT registers after element1/element2, result = {dirty, a+b mod 2^24}.
    logic [LAT-1:0][24:0] mpipe;
    always @(posedge clock)
        mpipe <= {mpipe[LAT-2:0], {element1[24], 24'(element1[23:0] + element2)}};
    assign new1 = mpipe[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("no_overflow", 32'(exp_q.size() <= DEPTH), 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_tag", out_tag, e.tag);
                    chk("out_dirty", out_dirty, e.d);
                end
            end
        end
    end

    function automatic void push_exp(input logic [23:0] a, b, input logic d, input logic [TAG_W-1:0] t);
`ifdef ARITH_ISSUE_DROP_DIRTY_EN
        if (!d) exp_q.push_back('{d: d, data: 24'(a + b), tag: t});
`else
        exp_q.push_back('{d: d, data: 24'(a + b), tag: t});
`endif
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the pair.
    task automatic issue(input logic [23:0] a, b, input logic d, input logic [TAG_W-1:0] t,
                         output int stalls);
        int n = 0;
        in_valid = 1; in_a = a; in_b = b; in_dirty = d; in_tag = t;
        @(negedge clock);
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        stalls = n;
        if (!in_ready) chk("issue_timeout", 1, 0);
        else           push_exp(a, b, d, t);
        @(posedge clock); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(posedge clock);
            n++;
        end while (exp_q.size() != 0 && n < 200);
        #1;
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int st, tot, j;
        logic seen;
        reset = 1; in_valid = 0; in_a = 0; in_b = 0; in_dirty = 0; in_tag = 0; out_ready = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_element1", element1, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        reset = 0;
        @(negedge clock);
        chk("in_ready_after_rst", in_ready, 1);
        @(posedge clock); #1;

        // Single pair: latency and inflight
        issue(24'h000010, 24'h000005, 0, 4'd3, st);
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clock);
            chk("single_ovalid_low", out_valid, 0);
            if (k == 0) chk("single_inflight1", inflight, 1);
        end
        @(negedge clock);
        chk("single_ovalid_high", out_valid, 1);
        chk("single_inflight0", inflight, 0);
        @(posedge clock); #1;
        out_ready = 1;
        drain();

        // Streaming
        tot = 0;
        for (int i = 0; i < 20; i++) begin
            issue(24'(i), 24'(2 * i), 0, TAG_W'(i), st);
            tot += st;
        end
        chk("stream_no_stall", tot, 0);
        drain();

        // Backpressure
        out_ready = 0; j = 0;
        for (int c = 0; c < 60 && j < 12; c++) begin
            if (c == 30) begin
                chk("bp_accepted8", j, 8);
                chk("bp_in_ready0", in_ready, 0);
                chk("bp_queued8", exp_q.size(), 8);
                out_ready = 1;
            end
            in_valid = 1; in_a = 24'(100 + j); in_b = 24'(j); in_dirty = 0; in_tag = TAG_W'(j);
            @(negedge clock);
            if (in_ready) begin
                push_exp(in_a, in_b, 0, in_tag);
                j++;
            end
            @(posedge clock); #1;
        end
        in_valid = 0;
        chk("bp_accepted12", j, 12);
        drain();

        // Dirty pair
        issue(24'h1, 24'h1, 1, 4'd5, st);
        repeat (LAT + 4) @(posedge clock);
        #1;
`ifdef ARITH_ISSUE_DROP_DIRTY_EN
        chk("dirty_drop_cnt", drop_cnt, 1);
        chk("dirty_no_output", out_valid, 0);
`else
        chk("dirty_drop_cnt", drop_cnt, 0);
`endif
        drain();

        // Reset mid-flight
        for (int k = 0; k < 3; k++) issue(24'(200 + k), 24'(k), 0, TAG_W'(8 + k), st);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1;
        exp_q.delete();
        @(posedge clock); #1;
        reset = 0;
        seen = 0;
        repeat (3 * LAT) begin
            @(negedge clock);
            if (out_valid) seen = 1;
        end
        chk("rst_mid_no_output", seen, 0);
        chk("rst_mid_inflight", inflight, 0);
        chk("rst_mid_drop_cnt", drop_cnt, 0);
        @(posedge clock); #1;
        issue(24'h7FFFFF, 24'h800001, 0, 4'hA, st);
        drain();

        // Push and pop on the same edge at the credit boundary
        out_ready = 0;
        for (int k = 0; k < 7; k++) issue(24'(k), 24'h10, 0, TAG_W'(k), st);
        repeat (LAT + 3) @(posedge clock);
        #1;
        chk("edge_fifo7_ready", in_ready, 1);
        issue(24'h55, 24'h11, 0, 4'h7, st);
        chk("edge_full_ready0", in_ready, 0);
        repeat (LAT) @(posedge clock);
        #1;
        chk("edge_before_ready0", in_ready, 0);
        chk("edge_before_inflight", inflight, 1);
        out_ready = 1;
        @(posedge clock); #1;
        out_ready = 0;
        chk("edge_inflight0", inflight, 0);
        chk("edge_in_ready1", in_ready, 1);
        chk("edge_out_valid", out_valid, 1);
        out_ready = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
